// File: rtl/obi_rr_arbiter.sv
// Purpose: two-requester OBI round-robin arbiter onto one shared target port, in-order response routing.
// Latency: zero; grant is combinational through the block, responses routed in the rvalid cycle.
// Backpressure: shared request held off while MAX_OUTSTANDING responses pend; a stalled selection is locked until granted.
module obi_rr_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // requester 0
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  // requester 1
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  // shared target
  output logic        shr_req_o,
  input  logic        shr_gnt_i,
  output logic [31:0] shr_addr_o,
  output logic        shr_we_o,
  output logic [3:0]  shr_be_o,
  output logic [31:0] shr_wdata_o,
  input  logic        shr_rvalid_i,
  input  logic [31:0] shr_rdata_i,
  // protocol violation flag
  output logic        bad_state_o
);

  localparam int            PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]    MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic                       last_q;
  logic                       lock_q;
  logic                       lock_sel_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wptr_q;
  logic [PW-1:0]              rptr_q;
  logic [2:0]                 count_q;
  logic                       bad_state_q;

  logic sel;
  logic sel_req;
  logic full;
  logic nonempty;
  logic push;
  logic pop;
  logic head;

  // Requester selection: a stalled selection wins, then a lone requester, then round-robin on a tie.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
      sel = ~last_q;
    end
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign full      = (count_q == MAX_CNT);
  assign nonempty  = (count_q != 3'd0);
  // Full blocks the request even in a pop cycle: the slot frees only after the edge.
  assign shr_req_o = sel_req && !full;
  assign push      = shr_req_o && shr_gnt_i;
  assign pop       = shr_rvalid_i && nonempty;
  assign head      = fifo_q[rptr_q];

  assign shr_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign shr_we_o    = sel ? m1_we_i    : m0_we_i;
  assign shr_be_o    = sel ? m1_be_i    : m0_be_i;
  assign shr_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = push && !sel;
  assign m1_gnt_o = push &&  sel;

  assign m0_rvalid_o = pop && !head;
  assign m1_rvalid_o = pop &&  head;
  assign m0_rdata_o  = shr_rdata_i;
  assign m1_rdata_o  = shr_rdata_i;

  assign bad_state_o = bad_state_q;

  // Arbitration history and the no-retract lock on a stalled shared request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else if (push) begin
      last_q <= sel;
      lock_q <= 1'b0;
    end else if (shr_req_o && !shr_gnt_i) begin
      lock_q     <= 1'b1;
      lock_sel_q <= sel;
    end
  end

  // Response-ID FIFO: records which requester owns each outstanding transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      end
    end
  end

  // Outstanding count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 3'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Flag a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bad_state_q <= 1'b0;
    end else begin
      bad_state_q <= shr_rvalid_i && !nonempty;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Purpose: self-checking bench for obi_rr_arbiter using expected-grant and expected-response queues.
// Latency: inputs driven just after the falling edge, outputs sampled 1 time unit later.
// Backpressure: shared grant and rvalid are driven directly by the bench per scenario.
module tb_obi_rr_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h1000_0004;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        shr_req_o, shr_gnt_i, shr_we_o, shr_rvalid_i;
  logic [31:0] shr_addr_o, shr_wdata_o, shr_rdata_i;
  logic [3:0]  shr_be_o;
  logic        bad_state_o;

  int n_cmp = 0;
  int n_err = 0;
  int resp_q[$];   // expected owner (0/1) of each outstanding response

  obi_rr_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .shr_req_o(shr_req_o), .shr_gnt_i(shr_gnt_i), .shr_addr_o(shr_addr_o), .shr_we_o(shr_we_o),
    .shr_be_o(shr_be_o), .shr_wdata_o(shr_wdata_o), .shr_rvalid_i(shr_rvalid_i),
    .shr_rdata_i(shr_rdata_i), .bad_state_o(bad_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    m0_req_i = 1'b0; m1_req_i = 1'b0; shr_gnt_i = 1'b0;
    shr_rvalid_i = 1'b0; shr_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    m0_addr_i = A0; m0_we_i = 1'b1; m0_be_i = 4'hF; m0_wdata_i = 32'h0000_AAAA;
    m1_addr_i = A1; m1_we_i = 1'b0; m1_be_i = 4'h3; m1_wdata_i = 32'h0000_BBBB;
    shr_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({shr_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, bad_state_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got req/g0/g1/rv0/rv1/bad=%b required 000000",
               {shr_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, bad_state_o});
    end
    shr_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (bad_state_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_bad_state got %b required 0", bad_state_o);
    end
    @(negedge clk_i);
  endtask

  // Tie with continuous grant; responses returned from the second cycle on.
  task automatic test_tie();
    int exp_gnt[$];
    int g;
    int e;
    exp_gnt = '{0, 1, 0, 1};
    m0_req_i = 1'b1; m1_req_i = 1'b1; shr_gnt_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin m0_req_i = 1'b0; m1_req_i = 1'b0; end
      shr_rvalid_i = (c > 0);
      shr_rdata_i  = 32'hC000_0000 + c;
      #1;
      if (shr_rvalid_i) begin
        e = resp_q.pop_front();
        n_cmp++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {e == 0, e == 1, shr_rdata_i, shr_rdata_i}) begin
          n_err++;
          $display("FAIL tie_resp c=%0d got rv0=%b rv1=%b rd0=%h rd1=%h required owner m%0d data %h",
                   c, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, e, shr_rdata_i);
        end
      end
      if (exp_gnt.size() > 0) begin
        g = exp_gnt.pop_front();
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o, shr_addr_o, shr_wdata_o, shr_be_o, shr_we_o} !==
            {g == 0, g == 1, (g == 1) ? A1 : A0, (g == 1) ? m1_wdata_i : m0_wdata_i,
             (g == 1) ? m1_be_i : m0_be_i, (g == 1) ? m1_we_i : m0_we_i}) begin
          n_err++;
          $display("FAIL tie_gnt c=%0d got g0=%b g1=%b addr=%h wdata=%h required m%0d",
                   c, m0_gnt_o, m1_gnt_o, shr_addr_o, shr_wdata_o, g);
        end
        resp_q.push_back(g);
      end
      @(negedge clk_i);
    end
    idle();
  endtask

  // m1 stalls for three cycles, m0 joins, lock keeps m1 until granted, then m0 next.
  task automatic test_stall_lock();
    int e;
    m1_req_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) m0_req_i = 1'b1;
      shr_gnt_i = (c == 4);
      #1;
      n_cmp++;
      if ({shr_req_o, shr_addr_o, m0_gnt_o, m1_gnt_o} !== {1'b1, A1, 1'b0, c == 4}) begin
        n_err++;
        $display("FAIL stall_lock c=%0d got req=%b addr=%h g0=%b g1=%b required req=1 addr=%h g1=%b",
                 c, shr_req_o, shr_addr_o, m0_gnt_o, m1_gnt_o, A1, c == 4);
      end
      @(negedge clk_i);
    end
    resp_q.push_back(1);
    #1;
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o, shr_addr_o} !== {1'b1, 1'b0, A0}) begin
      n_err++;
      $display("FAIL stall_next got g0=%b g1=%b addr=%h required g0=1 addr=%h", m0_gnt_o, m1_gnt_o, shr_addr_o, A0);
    end
    resp_q.push_back(0);
    @(negedge clk_i);
    idle();
    for (int c = 0; c < 2; c++) begin
      shr_rvalid_i = 1'b1;
      shr_rdata_i  = 32'hD000_0000 + c;
      #1;
      e = resp_q.pop_front();
      n_cmp++;
      if ({m0_rvalid_o, m1_rvalid_o} !== {e == 0, e == 1}) begin
        n_err++;
        $display("FAIL stall_resp c=%0d got rv0=%b rv1=%b required owner m%0d", c, m0_rvalid_o, m1_rvalid_o, e);
      end
      @(negedge clk_i);
    end
    idle();
  endtask

  // Two grants fill the ID FIFO; request held off, including in the pop cycle.
  task automatic test_full();
    int e;
    m0_req_i = 1'b1; shr_gnt_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      shr_rvalid_i = (c == 4);
      #1;
      n_cmp++;
      if ({shr_req_o, m0_gnt_o} !== {2{c < 2 || c == 5}}) begin
        n_err++;
        $display("FAIL full_req c=%0d got req=%b g0=%b required %b", c, shr_req_o, m0_gnt_o, c < 2 || c == 5);
      end
      if (shr_rvalid_i) begin
        e = resp_q.pop_front();
        n_cmp++;
        if ({m0_rvalid_o, m1_rvalid_o} !== {e == 0, e == 1}) begin
          n_err++;
          $display("FAIL full_resp c=%0d got rv0=%b rv1=%b required owner m%0d", c, m0_rvalid_o, m1_rvalid_o, e);
        end
      end
      if (m0_gnt_o) resp_q.push_back(0);
      @(negedge clk_i);
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      shr_rvalid_i = 1'b1;
      #1;
      e = resp_q.pop_front();
      n_cmp++;
      if ({m0_rvalid_o, m1_rvalid_o} !== {e == 0, e == 1}) begin
        n_err++;
        $display("FAIL full_drain c=%0d got rv0=%b rv1=%b required owner m%0d", c, m0_rvalid_o, m1_rvalid_o, e);
      end
      @(negedge clk_i);
    end
    idle();
  endtask

  // m0 then m1 granted; responses routed in order with their data.
  task automatic test_in_order();
    logic [31:0] rd [2];
    int e;
    rd[0] = 32'hA5A5_A5A5;
    rd[1] = 32'h5A5A_5A5A;
    m0_addr_i = 32'h2000_0000;
    m1_addr_i = 32'h2000_0004;
    shr_gnt_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      m0_req_i = (c == 0);
      m1_req_i = (c == 1);
      #1;
      n_cmp++;
      if ({m0_gnt_o, m1_gnt_o, shr_addr_o} !== {c == 0, c == 1, 32'h2000_0000 + 32'(4 * c)}) begin
        n_err++;
        $display("FAIL order_gnt c=%0d got g0=%b g1=%b addr=%h", c, m0_gnt_o, m1_gnt_o, shr_addr_o);
      end
      resp_q.push_back(c);
      @(negedge clk_i);
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      shr_rvalid_i = 1'b1;
      shr_rdata_i  = rd[c];
      #1;
      e = resp_q.pop_front();
      n_cmp++;
      if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {e == 0, e == 1, rd[c], rd[c]}) begin
        n_err++;
        $display("FAIL order_resp c=%0d got rv0=%b rv1=%b rd0=%h rd1=%h required owner m%0d data %h",
                 c, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, e, rd[c]);
      end
      @(negedge clk_i);
    end
    idle();
    m0_addr_i = A0;
    m1_addr_i = A1;
  endtask

  // Response with nothing outstanding: no routing, one-cycle flag.
  task automatic test_stray();
    for (int c = 0; c < 3; c++) begin
      shr_rvalid_i = (c == 0);
      #1;
      n_cmp++;
      if ({m0_rvalid_o, m1_rvalid_o, bad_state_o} !== {2'b00, c == 1}) begin
        n_err++;
        $display("FAIL stray c=%0d got rv0=%b rv1=%b bad=%b required bad=%b",
                 c, m0_rvalid_o, m1_rvalid_o, bad_state_o, c == 1);
      end
      @(negedge clk_i);
    end
    idle();
  endtask

  // Reset with one transfer outstanding and bad_state high; both clear without a clock edge.
  task automatic test_reset_mid();
    int e;
    m0_req_i = 1'b1; shr_gnt_i = 1'b1; shr_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({m0_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 3'b100) begin
      n_err++;
      $display("FAIL rmid_setup got g0=%b rv0=%b rv1=%b required 100", m0_gnt_o, m0_rvalid_o, m1_rvalid_o);
    end
    @(negedge clk_i);
    idle();
    shr_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({bad_state_o, m0_rvalid_o} !== 2'b11) begin
      n_err++;
      $display("FAIL rmid_pre got bad=%b rv0=%b required 11", bad_state_o, m0_rvalid_o);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({bad_state_o, m0_rvalid_o, m1_rvalid_o} !== 3'b000) begin
      n_err++;
      $display("FAIL rmid_async got bad=%b rv0=%b rv1=%b required 000", bad_state_o, m0_rvalid_o, m1_rvalid_o);
    end
    shr_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    m0_req_i = 1'b1; m1_req_i = 1'b1; shr_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      n_err++;
      $display("FAIL rmid_tie got g0=%b g1=%b required 10", m0_gnt_o, m1_gnt_o);
    end
    resp_q.push_back(0);
    @(negedge clk_i);
    idle();
    for (int c = 0; c < 3; c++) begin
      shr_rvalid_i = (c < 2);
      #1;
      if (c == 0) begin
        e = resp_q.pop_front();
        n_cmp++;
        if ({m0_rvalid_o, m1_rvalid_o} !== {e == 0, e == 1}) begin
          n_err++;
          $display("FAIL rmid_resp got rv0=%b rv1=%b required owner m%0d", m0_rvalid_o, m1_rvalid_o, e);
        end
      end else begin
        n_cmp++;
        if ({m0_rvalid_o, m1_rvalid_o, bad_state_o} !== {2'b00, c == 2}) begin
          n_err++;
          $display("FAIL rmid_stray c=%0d got rv0=%b rv1=%b bad=%b required bad=%b",
                   c, m0_rvalid_o, m1_rvalid_o, bad_state_o, c == 2);
        end
      end
      @(negedge clk_i);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_stall_lock();
    test_full();
    test_in_order();
    test_stray();
    test_reset_mid();
    n_cmp++;
    if (resp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", resp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obi_rr_arbiter.md
OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the number of granted transactions awaiting rvalid on the shared port (legal 1..4).
REQ-002 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports m0_req_i in 1, m0_gnt_o out 1, m0_addr_i in 32, m0_we_i in 1, m0_be_i in 4, m0_wdata_i in 32, m0_rvalid_o out 1, m0_rdata_o out 32; these form the OBI requester 0 port.
REQ-005 SHALL have the same eight ports with prefix m1_; these form the OBI requester 1 port.
REQ-006 SHALL have ports shr_req_o out 1, shr_gnt_i in 1, shr_addr_o out 32, shr_we_o out 1, shr_be_o out 4, shr_wdata_o out 32, shr_rvalid_i in 1, shr_rdata_i in 32; these form the shared OBI target port.
REQ-007 SHALL have port bad_state_o  output  1  registered one-cycle pulse on a protocol violation.

Function
REQ-008 SHALL hold this state: last_q (index of last granted requester), lock_q/lock_sel_q (pending un-granted selection), an ID FIFO of MAX_OUTSTANDING 1-bit entries, and count (0..MAX_OUTSTANDING).
REQ-009 SHALL select the requester (sel) as follows, in priority order: lock_sel_q when lock_q=1; else the only requesting master; else, when both request, the master != last_q.
REQ-010 SHALL drive shr_req_o = (selected req) AND (count < MAX_OUTSTANDING); shr_addr/we/be/wdata SHALL be a combinational mux of the selected master's fields.
REQ-011 SHALL drive mX_gnt_o = shr_gnt_i AND shr_req_o AND (sel==X); the non-selected master's gnt SHALL be 0.
REQ-012 SHALL treat an accepted transfer as shr_req_o AND shr_gnt_i; on acceptance, push sel into the FIFO, set last_q=sel and clear lock_q.
REQ-013 SHALL, when shr_req_o=1 and shr_gnt_i=0, set lock_q=1 and lock_sel_q=sel, so the shared request and address stay stable until granted (the OBI no-retract rule).
REQ-014 SHALL drive mX_rvalid_o = shr_rvalid_i AND (count>0) AND (FIFO head==X); m0_rdata_o and m1_rdata_o SHALL both equal shr_rdata_i.
REQ-015 SHALL pop the FIFO on shr_rvalid_i when count>0; responses are strictly in order.
REQ-016 SHALL handle a push and a pop in the same cycle by leaving count unchanged and keeping the FIFO order correct.
REQ-017 SHALL, when count==MAX_OUTSTANDING, hold shr_req_o=0 that cycle even if a pop occurs; lock_q is unaffected while full.
REQ-018 SHALL handle shr_rvalid_i with count==0 as follows: no pop, no master rvalid, and bad_state_o=1 on the next cycle.
REQ-019 SHALL treat FIFO pointers as wrap-around modulo MAX_OUTSTANDING.
REQ-020 SHALL add no latency: the grant is combinational through the block, and the response is routed in the same cycle as shr_rvalid_i.

Reset
REQ-021 SHALL, while rst_ni=0, clear all state immediately: last_q=1 (so m0 wins the first tie), lock_q=0, lock_sel_q=0, count=0, FIFO pointers=0, bad_state_o=0.
REQ-022 SHALL, with count=0 after reset, drive all rvalid outputs to 0; shr_req_o and the gnt outputs then follow the inputs per REQ-010/011.
REQ-023 SHALL discard any transactions outstanding at reset (a reset mid-operation drops them); a later stray shr_rvalid_i SHALL be flagged per REQ-018.

Verification
REQ-024 SHALL cover a tie: m0_req_i=m1_req_i=1 and shr_gnt_i=1 continuously after reset -> grants m0,m1,m0,m1 on consecutive cycles, and shr_addr_o alternates between m0_addr_i and m1_addr_i.
REQ-025 SHALL cover a stall lock: m1 alone requests with shr_gnt_i=0 for 3 cycles, then m0 also requests -> shr_addr_o stays m1_addr_i until shr_gnt_i=1, m1_gnt_o pulses, and m0 is granted next.
REQ-026 SHALL cover the full condition: MAX_OUTSTANDING=2, two grants and no rvalid -> shr_req_o=0 while requests remain; one shr_rvalid_i -> shr_req_o reasserts the next cycle.
REQ-027 SHALL cover in-order routing: grant m0 (addr 0x20000000) then m1 (addr 0x20000004); rvalid with rdata 0xA5A5A5A5 then 0x5A5A5A5A -> m0_rvalid_o then m1_rvalid_o, with matching data.
REQ-028 SHALL cover a stray response: shr_rvalid_i=1 with count=0 -> no master rvalid, and bad_state_o=1 for exactly one cycle.
REQ-029 SHALL cover reset mid-operation: assert rst_ni=0 with count=1 -> count=0 and bad_state_o=0 asynchronously, and the next tie grants m0.
